apb_rr_master_arbiter: RTL and testbench

APB master front-end that shares one APB slave port (the UART_APB peripheral) between NUM_REQ on-chip requesters. It arbitrates pending transfer requests round-robin and sequences the APB SETUP/ACCESS phases. It returns read data and completion status to the granted requester, and aborts transfers whose PREADY never arrives. It sits between the requesters (CPU port, DMA, test port) and the PADDR/PWDATA/PSELx/PENABLE/PWRITE/PSTRB/PREADY/PRDATA pins of the slave.

---
 rtl/apb_rr_master_arbiter.sv | 120 ++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master_arbiter.sv
// APB master front-end sharing one slave port between NUM_REQ requesters.
// Round-robin grant, SETUP/ACCESS sequencing, and timeout abort of stalled transfers.
module apb_rr_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255,
  parameter int IDX_W   = 1
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  input  logic [4*NUM_REQ-1:0]   req_strb,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [31:0]            rdata,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx,
  output logic [31:0]            PADDR,
  output logic [31:0]            PWDATA,
  output logic                   PWRITE,
  output logic [3:0]             PSTRB,
  output logic                   PSELx,
  output logic                   PENABLE,
  input  logic                   PREADY,
  input  logic [31:0]            PRDATA
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] cand;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               timeout_hit;
  logic               finish;
  logic               do_grant;

  // The completing requester is excluded so a held req cannot win twice in a row.
  always_comb begin
    cand = req;
    if (state == ACCESS) cand = req & ~(NUM_REQ'(1) << grant_idx);
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && cand[(int'(ptr) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt) + 32'd1) >= 32'(TIMEOUT));
  assign finish      = (state == ACCESS) && (PREADY || timeout_hit);
  assign do_grant    = pick_found && ((state == IDLE) || finish);
  assign busy        = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      grant_idx <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSTRB     <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      done  <= '0;
      err   <= 1'b0;
      rdata <= '0;
      case (state)
        SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (finish) begin
            done    <= NUM_REQ'(1) << grant_idx;
            err     <= !PREADY;
            rdata   <= (PREADY && !PWRITE) ? PRDATA : 32'h0;
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      // A grant overrides the IDLE return above for back-to-back transfers.
      if (do_grant) begin
        grant_idx <= pick_idx;
        ptr       <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
        PADDR     <= req_addr[int'(pick_idx)*32 +: 32];
        PWDATA    <= req_wdata[int'(pick_idx)*32 +: 32];
        PWRITE    <= req_write[pick_idx];
        PSTRB     <= req_write[pick_idx] ? req_strb[int'(pick_idx)*4 +: 4] : 4'h0;
        PSELx     <= 1'b1;
        PENABLE   <= 1'b0;
        state     <= SETUP;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Randomized and directed bench for apb_rr_master_arbiter against a transfer-age reference model.
module tb_apb_rr_master_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;
  localparam int TO = 4;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req, req_write;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [4*N-1:0]  req_strb;
  logic [N-1:0]    done;
  logic            err, busy;
  logic [31:0]     rdata;
  logic [IW-1:0]   grant_idx;
  logic [31:0]     PADDR, PWDATA, PRDATA;
  logic            PWRITE, PSELx, PENABLE, PREADY;
  logic [3:0]      PSTRB;

  always #5 PCLK = ~PCLK;

  apb_rr_master_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .IDX_W(IW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .done(done), .err(err), .rdata(rdata), .busy(busy), .grant_idx(grant_idx),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PSELx(PSELx), .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a transfer is described by its owner and its age in cycles since grant.
  bit          m_act;
  int          m_own, m_age, m_prio, m_gidx;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          m_write, m_err;
  logic [3:0]  m_strb;
  logic [N-1:0] m_done;

  function automatic int rr_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 0; m_own = 0; m_age = 0; m_prio = 0; m_gidx = 0;
    m_addr = '0; m_wdata = '0; m_write = 0; m_strb = '0;
    m_done = '0; m_err = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit fin;
    int w;
    logic [N-1:0] cand;
    fin = 0;
    m_done = '0; m_err = 0; m_rdata = '0;
    if (m_act) begin
      if (m_age >= 1 && PREADY) begin
        fin = 1; m_done[m_own] = 1'b1; m_rdata = m_write ? 32'h0 : PRDATA;
      end else if (m_age >= 1 && TO != 0 && m_age == TO) begin
        fin = 1; m_done[m_own] = 1'b1; m_err = 1;
      end else begin
        m_age++;
      end
    end
    if (!m_act || fin) begin
      cand = req;
      if (fin) cand[m_own] = 1'b0;
      w = rr_pick(cand, m_prio);
      if (w >= 0) begin
        m_act = 1; m_own = w; m_gidx = w; m_age = 0;
        m_addr  = req_addr[32*w +: 32];
        m_wdata = req_wdata[32*w +: 32];
        m_write = req_write[w];
        m_strb  = req_write[w] ? req_strb[4*w +: 4] : 4'h0;
        m_prio  = (w + 1) % N;
      end else begin
        m_act = 0;
      end
    end
  endtask

  task automatic compare_outs(input string ph);
    chk({ph, ".ctl"}, {PSELx, PENABLE, busy, grant_idx, err},
        {m_act, (m_act && m_age >= 1), m_act, IW'(m_gidx), m_err});
    chk({ph, ".done"}, 64'(done), 64'(m_done));
    chk({ph, ".rdata"}, 64'(rdata), 64'(m_rdata));
    chk({ph, ".paddr"}, 64'(PADDR), 64'(m_addr));
    chk({ph, ".pwdata"}, 64'(PWDATA), 64'(m_wdata));
    chk({ph, ".pwr_strb"}, {PWRITE, PSTRB}, {m_write, m_strb});
  endtask

  task automatic tick(input string ph);
    model_step();
    @(posedge PCLK);
    @(negedge PCLK);
    compare_outs(ph);
  endtask

  task automatic set_cmd(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[i] = wr;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
    req_strb[4*i +: 4] = s;
  endtask

  task automatic chk_zero_outs(input string ph);
    chk({ph, ".ctl0"}, {done, err, busy, grant_idx, PSELx, PENABLE, PWRITE, PSTRB}, 64'h0);
    chk({ph, ".rdata0"}, 64'(rdata), 64'h0);
    chk({ph, ".apb0"}, {PADDR, PWDATA}, 64'h0);
  endtask

  initial begin
    int psel_cnt, pen_cnt, err_cnt, stall;
    logic [31:0] got_rd;
    int order[$];
    int exp_order[4];

    req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    PREADY = 1'b0; PRDATA = '0; PRESETn = 1'b1;
    model_reset();
    #2 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_zero_outs("reset");
    PRESETn = 1'b1;

    // Single zero-wait write
    set_cmd(0, 1, 32'h0, 32'h41, 4'hF);
    req = 3'b001; PREADY = 1'b1;
    psel_cnt = 0; pen_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick("t1");
      psel_cnt += int'(PSELx); pen_cnt += int'(PENABLE);
      req = req & ~m_done;
    end
    chk("t1.psel_cycles", 64'(psel_cnt), 64'd2);
    chk("t1.pen_cycles", 64'(pen_cnt), 64'd1);

    // Read with three wait states
    set_cmd(1, 0, 32'h4, 32'h0, 4'h0);
    req = 3'b010; PRDATA = 32'h5A; pen_cnt = 0; got_rd = '0;
    for (int c = 0; c < 10; c++) begin
      PREADY = (m_act && m_age >= 4);
      tick("t2");
      pen_cnt += int'(PENABLE);
      if (done[1]) got_rd = rdata;
      req = req & ~m_done;
    end
    chk("t2.pen_cycles", 64'(pen_cnt), 64'd4);
    chk("t2.rdata", 64'(got_rd), 64'h5A);

    // Contention between 0 and 1, both held
    set_cmd(0, 1, 32'h10, 32'h100, 4'h3);
    set_cmd(1, 1, 32'h14, 32'h101, 4'hC);
    req = 3'b011; PREADY = 1'b1;
    for (int c = 0; c < 20 && order.size() < 4; c++) begin
      tick("t3");
      for (int i = 0; i < N; i++) if (done[i]) order.push_back(i);
    end
    req = '0;
    exp_order = '{0, 1, 0, 1};
    chk("t3.count", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk($sformatf("t3.order%0d", i), 64'(order[i]), 64'(exp_order[i]));
    repeat (3) tick("t3.idle");

    // Timeout abort
    set_cmd(0, 1, 32'h8, 32'hDEAD, 4'hF);
    req = 3'b001; PREADY = 1'b0; pen_cnt = 0; err_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick("t4");
      pen_cnt += int'(PENABLE);
      if (err && done[0] && rdata == 32'h0) err_cnt++;
      req = req & ~m_done;
    end
    chk("t4.pen_cycles", 64'(pen_cnt), 64'd4);
    chk("t4.abort", 64'(err_cnt), 64'd1);

    // Read with strobes offered: bus strobes must be zero
    set_cmd(2, 0, 32'hC, 32'h0, 4'hF);
    req = 3'b100; PREADY = 1'b1; PRDATA = 32'h77;
    tick("t5");
    chk("t5.pstrb", {PSELx, PSTRB}, {1'b1, 4'h0});
    repeat (3) begin tick("t5"); req = req & ~m_done; end

    // Asynchronous reset while in ACCESS
    set_cmd(0, 1, 32'h20, 32'h55, 4'hF);
    req = 3'b001; PREADY = 1'b0;
    tick("t6"); tick("t6");
    chk("t6.pen_before", 64'(PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    chk_zero_outs("t6.async");
    model_reset();
    @(negedge PCLK);
    chk_zero_outs("t6.held");
    PRESETn = 1'b1;
    req = 3'b010; PREADY = 1'b1;
    set_cmd(1, 1, 32'h24, 32'h66, 4'h1);
    tick("t6.post");
    chk("t6.first_grant", {PSELx, grant_idx}, {1'b1, 2'd1});
    req = 3'b011;
    repeat (8) tick("t6.post");
    req = '0;
    repeat (3) tick("t6.idle");

    // Randomized traffic with occasional long stalls
    stall = 0;
    for (int c = 0; c < 3000; c++) begin
      req_addr  = {$urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom};
      req_strb  = 12'($urandom);
      req_write = 3'($urandom);
      PRDATA    = $urandom;
      if (stall > 0) stall--;
      else if ($urandom_range(0, 19) == 0) stall = 6;
      PREADY = (stall == 0) && ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (m_done[i]) req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
